// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath: result collector FSM states,
// lane select encodings and the default per-lane result width.
package arith_pkg;

    // A 4-bit x 4-bit product needs 8 bits.
    localparam int unsigned RES_W_DEFAULT = 8;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/result_collect_4to1_op_watchdog.sv
// op_watchdog: cycle counter bounding the time an operation may wait for its
// lane to complete.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : restart the count from zero (takes priority over en)
//   en   : advance the count by one
//   tc   : terminal count, high while the count equals TIMEOUT_CYC-1
module op_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 16  // legal range 2..255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (clr) begin
            cnt_q <= 8'd0;
        end else if (en) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign tc = (cnt_q == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/result_collect_4to1.sv
// result_collect_4to1: collects the result of the one arithmetic lane chosen
// at issue time and presents it on a single valid/ready output. A watchdog
// aborts the operation (out_err=1, out_data=0) if the lane never completes.
//   clk, rst         : clock and synchronous active-high reset
//   start, opcode    : issue pulse and lane select (accepted only in IDLE)
//   done[3:0]        : per-lane completion pulses
//   res0..res3       : per-lane results, valid with the matching done bit
//   busy             : an operation is outstanding
//   out_valid/ready  : output handshake
//   out_data/op/err  : collected result, its lane and the timeout flag
module result_collect_4to1
    import arith_pkg::*;
#(
    parameter int unsigned RES_W       = RES_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [3:0]       done,
    input  logic [RES_W-1:0] res0,
    input  logic [RES_W-1:0] res1,
    input  logic [RES_W-1:0] res2,
    input  logic [RES_W-1:0] res3,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_data,
    output logic [1:0]       out_op,
    output logic             out_err
);

    state_e state_q, state_d;
    logic [1:0] op_q;

    logic             sel_done;
    logic [RES_W-1:0] sel_res;
    logic             wd_clr, wd_en, wd_tc;

    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [RES_W-1:0] data_q, data_d;
    logic [1:0]       op_out_q, op_out_d;
    logic             err_q, err_d;

    // Only the lane latched at issue time is observed.
    always_comb begin
        sel_done = 1'b0;
        sel_res  = '0;
        unique case (op_q)
            LANE0: begin sel_done = done[0]; sel_res = res0; end
            LANE1: begin sel_done = done[1]; sel_res = res1; end
            LANE2: begin sel_done = done[2]; sel_res = res2; end
            LANE3: begin sel_done = done[3]; sel_res = res3; end
            default: ;
        endcase
    end

    assign wd_clr = (state_q == ST_IDLE) && start;
    assign wd_en  = (state_q == ST_WAIT) && !sel_done;

    op_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_WAIT;
            ST_WAIT: if (sel_done || wd_tc) state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        valid_d  = (state_d == ST_HOLD);
        data_d   = data_q;
        op_out_d = op_out_q;
        err_d    = err_q;
        if (state_q == ST_WAIT) begin
            // A real completion wins over a coincident timeout.
            if (sel_done) begin
                data_d   = sel_res;
                op_out_d = op_q;
                err_d    = 1'b0;
            end else if (wd_tc) begin
                data_d   = '0;
                op_out_d = op_q;
                err_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= 2'd0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            op_out_q <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                op_q <= opcode;
            end
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            op_out_q <= op_out_d;
            err_q    <= err_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_op    = op_out_q;
    assign out_err   = err_q;

endmodule
